cfg_tgate_bank: RTL and testbench



---
 rtl/cfg_tgate_bank.sv | 111 +++++++++++
 tb/tb_cfg_tgate_bank.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_tgate_bank.sv
// cfg_tgate_bank: serially configured bank of routing gates (off / buf / inv / const0 / const1).
// Define CFG_PARITY_EN to append one even-parity bit to each configuration frame.
module cfg_tgate_bank #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 1
) (
    input  logic                     prog_clk,
    input  logic                     pReset,
    input  logic                     ccff_head,
    input  logic                     cfg_en,
    input  logic                     cfg_commit,
    output logic                     ccff_tail,
    output logic                     cfg_full,
    output logic                     cfg_err,
    output logic [NUM_CH-1:0]        ch_active,
    input  logic [NUM_CH*DATA_W-1:0] in,
    output wire  [NUM_CH*DATA_W-1:0] out
);

`ifdef CFG_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int MODE_BITS = 3 * NUM_CH;
    localparam int L         = MODE_BITS + P;
    localparam int CNT_W     = $clog2(L + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(L);

    typedef enum logic [2:0] {
        MODE_OFF = 3'b000,
        MODE_BUF = 3'b001,
        MODE_INV = 3'b010,
        MODE_C0  = 3'b011,
        MODE_C1  = 3'b100
    } mode_e;

    logic [L-1:0]              sr;
    logic [CNT_W-1:0]          cnt;
    logic [MODE_BITS-1:0]      mode_q;
    logic                      err_q;
    logic                      parity_ok;
    logic                      commit_ok;
    logic [NUM_CH*DATA_W-1:0]  gate_val;

    // A 'z input must not propagate: only a definite 1 (BUF) or 0 (INV) drives high.
    function automatic logic gate_bit(input logic [2:0] m, input logic d);
        logic r;
        r = 1'b0;
        case (m)
            MODE_BUF: if (d == 1'b1) r = 1'b1;
            MODE_INV: if (d == 1'b0) r = 1'b1;
            MODE_C1:  r = 1'b1;
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

    // Reserved codes behave as OFF and therefore do not mark the channel active.
    function automatic logic mode_drives(input logic [2:0] m);
        return (m == MODE_BUF) || (m == MODE_INV) || (m == MODE_C0) || (m == MODE_C1);
    endfunction

`ifdef CFG_PARITY_EN
    assign parity_ok = ~(^sr);
`else
    assign parity_ok = 1'b1;
`endif

    assign cfg_full  = (cnt == CNT_FULL);
    assign commit_ok = cfg_full && parity_ok;
    assign ccff_tail = sr[L-1];
    assign cfg_err   = err_q;

    // Shift has priority over commit; a commit in the same cycle is silently dropped.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            sr     <= '0;
            cnt    <= '0;
            mode_q <= {NUM_CH{MODE_OFF}};
            err_q  <= 1'b0;
        end else if (cfg_en) begin
            sr <= {sr[L-2:0], ccff_head};
            if (cnt != CNT_FULL) cnt <= cnt + CNT_W'(1);
        end else if (cfg_commit) begin
            if (commit_ok) begin
                mode_q <= sr[P +: MODE_BITS];
                cnt    <= '0;
                err_q  <= 1'b0;
            end else begin
                err_q  <= 1'b1;
            end
        end
    end

    always_comb begin
        gate_val  = '0;
        ch_active = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            ch_active[k] = mode_drives(mode_q[3*k +: 3]);
            for (int b = 0; b < DATA_W; b++) begin
                gate_val[k*DATA_W+b] = gate_bit(mode_q[3*k +: 3], in[k*DATA_W+b]);
            end
        end
    end

    for (genvar i = 0; i < NUM_CH*DATA_W; i++) begin : g_drv
        assign out[i] = ch_active[i/DATA_W] ? gate_val[i] : 1'bz;
    end

endmodule

// File: tb/tb_cfg_tgate_bank.sv
// Self-checking bench for cfg_tgate_bank: frame-history model plus directed literal checks.
module tb_cfg_tgate_bank;

    localparam int NCH = 4;
    localparam int DW  = 2;
`ifdef CFG_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int L = 3 * NCH + P;

    logic prog_clk   = 1'b0;
    logic pReset     = 1'b1;
    logic ccff_head  = 1'b0;
    logic cfg_en     = 1'b0;
    logic cfg_commit = 1'b0;
    logic ccff_tail;
    logic cfg_full;
    logic cfg_err;
    logic [NCH-1:0]    ch_active;
    logic [NCH*DW-1:0] din = '0;
    wire  [NCH*DW-1:0] dout;

    always #5 prog_clk = ~prog_clk;

    cfg_tgate_bank #(.NUM_CH(NCH), .DATA_W(DW)) dut (
        .prog_clk   (prog_clk),
        .pReset     (pReset),
        .ccff_head  (ccff_head),
        .cfg_en     (cfg_en),
        .cfg_commit (cfg_commit),
        .ccff_tail  (ccff_tail),
        .cfg_full   (cfg_full),
        .cfg_err    (cfg_err),
        .ch_active  (ch_active),
        .in         (din),
        .out        (dout)
    );

    int checks   = 0;
    int failures = 0;
    bit run_cmp  = 1'b0;

    // Model: every bit shifted since reset, bits since last commit, sticky error, committed modes.
    bit hist[$];
    int cnt_m = 0;
    bit err_m = 1'b0;
    int mode_m[NCH];
    logic [NCH*DW-1:0] cmp_mask;
    logic [L-1:0] fa, fb2;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int frame_bit(input int i);
        return int'(hist[hist.size()-L+i]);
    endfunction

    function automatic bit frame_parity_ok();
        int x;
        x = 0;
        if (P == 0) return 1'b1;
        for (int i = 0; i < L; i++) x = x ^ frame_bit(i);
        return (x == 0);
    endfunction

    task automatic model_edge(input logic en, input logic head, input logic commit, input logic rst);
        if (rst) begin
            hist.delete();
            cnt_m = 0;
            err_m = 1'b0;
            for (int k = 0; k < NCH; k++) mode_m[k] = 0;
        end else if (en) begin
            hist.push_back(head);
            if (cnt_m < L) cnt_m++;
        end else if (commit) begin
            if (cnt_m == L && frame_parity_ok()) begin
                for (int k = 0; k < NCH; k++) begin
                    mode_m[k] = 4*frame_bit(3*(NCH-1-k)) + 2*frame_bit(3*(NCH-1-k)+1)
                              + frame_bit(3*(NCH-1-k)+2);
                end
                cnt_m = 0;
                err_m = 1'b0;
            end else begin
                err_m = 1'b1;
            end
        end
    endtask

    function automatic logic [NCH-1:0] exp_active();
        logic [NCH-1:0] a;
        for (int k = 0; k < NCH; k++) a[k] = (mode_m[k] >= 1 && mode_m[k] <= 4);
        return a;
    endfunction

    function automatic logic [NCH*DW-1:0] exp_mask();
        logic [NCH*DW-1:0] m;
        for (int k = 0; k < NCH; k++)
            for (int b = 0; b < DW; b++) m[k*DW+b] = exp_active()[k];
        return m;
    endfunction

    function automatic logic [NCH*DW-1:0] exp_out();
        logic [NCH*DW-1:0] r;
        r = '0;
        for (int k = 0; k < NCH; k++)
            for (int b = 0; b < DW; b++)
                case (mode_m[k])
                    1: r[k*DW+b] = din[k*DW+b];
                    2: r[k*DW+b] = ~din[k*DW+b];
                    4: r[k*DW+b] = 1'b1;
                    default: r[k*DW+b] = 1'b0;
                endcase
        return r;
    endfunction

    function automatic logic exp_tail();
        if (hist.size() >= L) return hist[hist.size()-L];
        return 1'b0;
    endfunction

    always @(negedge prog_clk) begin
        if (run_cmp) begin
            cmp_mask = exp_mask();
            chk("m_out", dout & cmp_mask, exp_out() & cmp_mask);
            chk("m_active", ch_active, exp_active());
            chk("m_tail", ccff_tail, exp_tail());
            chk("m_full", cfg_full, cnt_m == L);
            chk("m_err", cfg_err, err_m);
        end
    end

    task automatic tick(input logic en, input logic head, input logic commit, input logic rst);
        cfg_en = en; ccff_head = head; cfg_commit = commit; pReset = rst;
        @(posedge prog_clk);
        model_edge(en, head, commit, rst);
        #1;
        cfg_en = 1'b0; cfg_commit = 1'b0; pReset = 1'b0;
    endtask

    // f[L-1] is shifted first; this shifts n bits starting at shift position from_i.
    task automatic shift_bits(input logic [L-1:0] f, input int from_i, input int n);
        for (int j = 0; j < n; j++) tick(1'b1, f[L-1-from_i-j], 1'b0, 1'b0);
    endtask

    function automatic logic [L-1:0] mk(input logic [2:0] m3, input logic [2:0] m2,
                                        input logic [2:0] m1, input logic [2:0] m0);
        logic [L-1:0] f;
        logic [3*NCH-1:0] mb;
        mb = {m3, m2, m1, m0};
        f = '0;
        f[L-1 -: 3*NCH] = mb;
        if (P == 1) f[0] = ^mb;
        return f;
    endfunction

    initial begin
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        run_cmp = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        chk("reset_active", ch_active, 4'b0000);
        chk("reset_full", cfg_full, 1'b0);
        chk("reset_err", cfg_err, 1'b0);
        chk("reset_tail", ccff_tail, 1'b0);

        // Full load and commit.
        din = 8'b10_01_11_00;
        shift_bits(mk(3'b100, 3'b011, 3'b010, 3'b001), 0, L);
        chk("load_full", cfg_full, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk("load_out", dout, 8'hC0);
        chk("load_active", ch_active, 4'b1111);
        chk("load_full_fall", cfg_full, 1'b0);
        din = 8'b01_10_00_11;
        #1;
        chk("comb_out", dout, 8'hCF);

        // Early commit rejected, then completed frame accepted.
        fb2 = mk(3'b001, 3'b000, 3'b111, 3'b010);
        shift_bits(fb2, 0, 7);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk("early_err", cfg_err, 1'b1);
        chk("early_out", dout, 8'hCF);
        shift_bits(fb2, 7, L-7);
        chk("early_sticky", cfg_err, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk("late_err", cfg_err, 1'b0);
        chk("late_out", dout & 8'hC3, 8'h40);
        chk("late_active", ch_active, 4'b1001);

        // Commit coincident with the last shifted bit is ignored.
        fb2 = mk(3'b010, 3'b001, 3'b100, 3'b011);
        shift_bits(fb2, 0, L-1);
        tick(1'b1, fb2[0], 1'b1, 1'b0);
        chk("simul_full", cfg_full, 1'b1);
        chk("simul_err", cfg_err, 1'b0);
        chk("simul_active", ch_active, 4'b1001);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk("simul_commit_out", dout, 8'hAC);

        // Chain passthrough: the previous frame emerges on ccff_tail in order.
        fa  = mk(3'b100, 3'b000, 3'b011, 3'b001);
        fb2 = mk(3'b001, 3'b010, 3'b000, 3'b100);
        shift_bits(fa, 0, L);
        for (int j = 0; j < L; j++) begin
            chk("chain_tail", ccff_tail, fa[L-1-j]);
            tick(1'b1, fb2[L-1-j], 1'b0, 1'b0);
        end
        chk("chain_full", cfg_full, 1'b1);
        din = 8'b11_01_10_00;
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk("chain_out", dout & 8'hF3, 8'hE3);
        chk("chain_active", ch_active, 4'b1101);

`ifdef CFG_PARITY_EN
        fa = mk(3'b001, 3'b001, 3'b001, 3'b001);
        shift_bits(fa, 0, L);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk("par_ok_active", ch_active, 4'b1111);
        chk("par_ok_err", cfg_err, 1'b0);
        fa = mk(3'b100, 3'b100, 3'b000, 3'b011);
        fa[5] = ~fa[5];
        shift_bits(fa, 0, L);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk("par_bad_err", cfg_err, 1'b1);
        chk("par_bad_active", ch_active, 4'b1111);
`endif

        // Reset mid-shift and reset coincident with commit.
        shift_bits(mk(3'b100, 3'b100, 3'b100, 3'b100), 0, 5);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_mid_active", ch_active, 4'b0000);
        chk("rst_mid_full", cfg_full, 1'b0);
        shift_bits(mk(3'b100, 3'b100, 3'b100, 3'b100), 0, L);
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        chk("rst_commit_active", ch_active, 4'b0000);
        chk("rst_commit_full", cfg_full, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk("empty_commit_err", cfg_err, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);

        run_cmp = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
